axi_traffic_gen: RTL and testbench

//   AXI4 master stage that drives axi_ram through its in_mosi_i/in_miso_o pair.
//   On start it does three things in order:
//     - writes one INCR burst of a seeded incrementing pattern;
//     - reads the same burst back;
//     - counts every read beat whose data, ID or LAST does not match.

---
 rtl/axi_traffic_gen.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_traffic_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_traffic_gen.sv
// AXI4 write-then-readback traffic generator: writes one INCR burst of seed+k, reads it back, counts bad beats.
// Optional watchdog: define AXI_TGEN_TIMEOUT_EN to add the stall counter and the timeout_o port.
module axi_traffic_gen #(
  parameter int          ID_W        = 4,
  parameter int          ADDR_W      = 16,
  parameter int          DATA_W      = 32,
  parameter int unsigned TGEN_ID     = 0,
  parameter int          TIMEOUT_CYC = 1024,
  localparam int         STRB_W      = DATA_W / 8,
  localparam int         AX_W        = ID_W + ADDR_W + 8 + 3 + 2 + 1,
  localparam int         MOSI_W      = 2 * AX_W + DATA_W + STRB_W + 4,
  localparam int         MISO_W      = 2 * ID_W + DATA_W + 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [7:0]        len_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [8:0]        err_cnt_o,
  output logic [MOSI_W-1:0] out_mosi_o,
  input  logic [MISO_W-1:0] out_miso_i,
`ifdef AXI_TGEN_TIMEOUT_EN
  output logic              timeout_o,
`endif
  output logic [2:0]        state_dbg_o
);

  // Handshakes: a beat transfers on a rising edge where VALID and READY are both high; VALID and
  // its payload are held stable until that edge, READY may be driven freely by the receiver.
  // Bus packing, MSB first:
  //   out_mosi_o = {awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid,
  //                 bready, arid, araddr, arlen, arsize, arburst, arvalid, rready}
  //   out_miso_i = {awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid}

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [ID_W-1:0] TGEN_ID_C = ID_W'(TGEN_ID);
  localparam logic [2:0]      AX_SIZE   = 3'($clog2(STRB_W));
  localparam logic [1:0]      AX_INCR   = 2'b01;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [7:0]          len_q, len_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [7:0]          beat_q, beat_d;
  logic [8:0]          err_q, err_d;

  logic                aw_ready, w_ready, b_valid, ar_ready, r_last, r_valid;
  logic [ID_W-1:0]     b_id, r_id;
  logic [1:0]          unused_b_resp, unused_r_resp;
  logic [DATA_W-1:0]   r_data;

  logic                aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic [DATA_W-1:0]   exp_data;
  logic                last_beat;
  logic                r_bad;
  logic [31:0]         span_end;
  logic                crosses_4k;

  assign {aw_ready, w_ready, b_id, unused_b_resp, b_valid,
          ar_ready, r_id, r_data, unused_r_resp, r_last, r_valid} = out_miso_i;

  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  // The burst must end at or before the next 4KB page boundary.
  assign span_end   = 32'(base_addr_i[11:0]) + (32'(len_i) + 32'd1) * 32'(STRB_W);
  assign crosses_4k = (span_end > 32'd4096);

  assign exp_data  = seed_q + DATA_W'(beat_q);
  assign last_beat = (beat_q == len_q);
  assign r_bad     = (r_data != exp_data) || (r_id != TGEN_ID_C) || (r_last != last_beat);

`ifdef AXI_TGEN_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        any_hs;
`else
  logic        unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    seed_d   = seed_q;
    beat_d   = beat_q;
    err_d    = err_q;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d = base_addr_i;
          len_d  = len_i;
          seed_d = seed_i;
          beat_d = '0;
          if (crosses_4k) begin
            err_d   = 9'd1;
            state_d = S_DONE;
          end else begin
            err_d   = '0;
            state_d = S_AW;
          end
        end
      end
      S_AW: begin
        aw_valid = 1'b1;
        if (aw_ready) state_d = S_W;
      end
      S_W: begin
        w_valid = 1'b1;
        if (w_ready) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_B;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_B: begin
        b_ready = 1'b1;
        if (b_valid) begin
          if (b_id != TGEN_ID_C) err_d = sat_inc(err_q);
          state_d = S_AR;
        end
      end
      S_AR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_d = S_R;
      end
      S_R: begin
        r_ready = 1'b1;
        if (r_valid) begin
          // At most one count per beat, however many fields are wrong.
          if (r_bad) err_d = sat_inc(err_q);
          if (r_last || last_beat) begin
            beat_d  = '0;
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef AXI_TGEN_TIMEOUT_EN
    any_hs    = (aw_valid && aw_ready) || (w_valid && w_ready) || (b_ready && b_valid) ||
                (ar_valid && ar_ready) || (r_ready && r_valid);
    timeout_d = timeout_q;
    if (state_q == S_IDLE && start_i) timeout_d = 1'b0;
    // Fire on the cycle whose edge would bring the counter to TIMEOUT_CYC.
    if (state_q != S_IDLE && state_q != S_DONE && !any_hs &&
        cnt_q == 16'(TIMEOUT_CYC - 1)) begin
      aw_valid  = 1'b0;
      w_valid   = 1'b0;
      b_ready   = 1'b0;
      ar_valid  = 1'b0;
      r_ready   = 1'b0;
      err_d     = sat_inc(err_q);
      beat_d    = '0;
      state_d   = S_DONE;
      timeout_d = 1'b1;
    end
    cnt_d = (any_hs || state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      beat_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

`ifdef AXI_TGEN_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign err_cnt_o   = err_q;
  assign state_dbg_o = state_q;

  assign out_mosi_o = {TGEN_ID_C, base_q, len_q, AX_SIZE, AX_INCR, aw_valid,
                       exp_data, {STRB_W{1'b1}}, last_beat, w_valid,
                       b_ready,
                       TGEN_ID_C, base_q, len_q, AX_SIZE, AX_INCR, ar_valid,
                       r_ready};

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Directed bench for axi_traffic_gen: table of runs against a behavioural AXI RAM slave, plus
// mid-run reset and (when AXI_TGEN_TIMEOUT_EN is defined) watchdog sequences.
module tb_axi_traffic_gen;

  localparam int MOSI_W = 108;
  localparam int MISO_W = 50;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  len;
    logic [31:0] seed;
    int          aw_stall;
    bit          w_toggle;
    int          bad_beat;
    logic [31:0] data_xor;
    bit          bad_rid;
    logic [8:0]  exp_err;
    int          exp_beats;
    int          exp_lat;
  } vec_t;

  logic              clk, rst, start;
  logic [15:0]       base;
  logic [7:0]        len;
  logic [31:0]       seed;
  logic              busy, done;
  logic [8:0]        err_cnt;
  logic [MOSI_W-1:0] mosi;
  logic [MISO_W-1:0] miso;
  logic [2:0]        state_dbg;
`ifdef AXI_TGEN_TIMEOUT_EN
  logic              timeout;
`endif

  logic [3:0]  m_aw_id, m_ar_id;
  logic [15:0] m_aw_addr, m_ar_addr;
  logic [7:0]  m_aw_len, m_ar_len;
  logic [2:0]  m_aw_size, m_ar_size;
  logic [1:0]  m_aw_burst, m_ar_burst;
  logic        m_aw_valid, m_ar_valid, m_w_last, m_w_valid, m_b_ready, m_r_ready;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;

  assign {m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_valid,
          m_w_data, m_w_strb, m_w_last, m_w_valid, m_b_ready,
          m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_valid, m_r_ready} = mosi;

  logic        s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_last, s_r_valid;
  logic [3:0]  s_b_id, s_r_id;
  logic [31:0] s_r_data;

  assign miso = {s_aw_ready, s_w_ready, s_b_id, 2'b00, s_b_valid,
                 s_ar_ready, s_r_id, s_r_data, 2'b00, s_r_last, s_r_valid};

  axi_traffic_gen #(
    .ID_W(4), .ADDR_W(16), .DATA_W(32), .TGEN_ID(0), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .len_i(len),
    .seed_i(seed), .busy_o(busy), .done_o(done), .err_cnt_o(err_cnt),
    .out_mosi_o(mosi), .out_miso_i(miso),
`ifdef AXI_TGEN_TIMEOUT_EN
    .timeout_o(timeout),
`endif
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int          n_checks, n_errors;
  logic [31:0] exp_q[$];
  int          w_beats, wdata_bad, wlast_bad, aw_bad, overlap_cnt, aw_valid_seen;
  logic [15:0] cur_base;
  logic [7:0]  cur_len;

  // slave configuration
  int          aw_stall_left;
  bit          cfg_w_toggle, cfg_bad_rid, cfg_no_b;
  int          cfg_bad_beat;
  logic [31:0] cfg_xor;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural AXI RAM slave + bus monitor ----------------
  logic [31:0] mem [0:16383];
  logic [13:0] w_idx, r_idx;
  int          r_beat;
  logic [7:0]  r_len;
  bit          b_pending, r_active, w_tog;
  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [31:0] exp_w;

  initial begin : slave
    s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0; s_b_id = 4'h0;
    s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_last = 1'b0; s_r_id = 4'h0; s_r_data = '0;
    b_pending = 0; r_active = 0; w_tog = 0; r_beat = 0; r_len = '0; w_idx = '0; r_idx = '0;
    forever begin
      @(negedge clk);
      hs_aw = m_aw_valid && s_aw_ready;
      hs_w  = m_w_valid && s_w_ready;
      hs_b  = m_b_ready && s_b_valid;
      hs_ar = m_ar_valid && s_ar_ready;
      hs_r  = m_r_ready && s_r_valid;
      if (int'(m_aw_valid) + int'(m_w_valid) + int'(m_ar_valid) > 1) overlap_cnt++;
      if (m_aw_valid) begin
        aw_valid_seen++;
        if (m_aw_addr != cur_base || m_aw_len != cur_len || m_aw_size != 3'd2 ||
            m_aw_burst != 2'b01 || m_aw_id != 4'd0) aw_bad++;
        if (aw_stall_left > 0) aw_stall_left--;
      end
      if (m_ar_valid && (m_ar_addr != cur_base || m_ar_len != cur_len || m_ar_size != 3'd2 ||
          m_ar_burst != 2'b01 || m_ar_id != 4'd0)) aw_bad++;
      if (hs_aw) w_idx = m_aw_addr[15:2];
      if (hs_w) begin
        w_beats++;
        if (exp_q.size() == 0) wdata_bad++;
        else begin
          exp_w = exp_q.pop_front();
          if (m_w_data !== exp_w || m_w_strb !== 4'hF) wdata_bad++;
        end
        if (m_w_last != (w_beats == int'(cur_len) + 1)) wlast_bad++;
        mem[w_idx] = m_w_data;
        w_idx++;
        if (m_w_last && !cfg_no_b) b_pending = 1;
      end
      if (hs_b) b_pending = 0;
      if (hs_ar) begin
        r_active = 1; r_beat = 0; r_idx = m_ar_addr[15:2]; r_len = m_ar_len;
      end else if (hs_r) begin
        r_beat++;
        r_idx++;
        if (r_beat > int'(r_len)) r_active = 0;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        b_pending = 0; r_active = 0; aw_stall_left = 0;
      end
      w_tog      = ~w_tog;
      s_aw_ready = (aw_stall_left == 0);
      s_w_ready  = cfg_w_toggle ? w_tog : 1'b1;
      s_b_valid  = b_pending;
      s_b_id     = 4'h0;
      s_ar_ready = 1'b1;
      s_r_valid  = r_active;
      s_r_data   = mem[r_idx] ^ ((r_beat == cfg_bad_beat) ? cfg_xor : 32'h0);
      s_r_id     = (r_beat == cfg_bad_beat && cfg_bad_rid) ? 4'h5 : 4'h0;
      s_r_last   = (r_beat == int'(r_len));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input vec_t v);
    cfg_w_toggle  = v.w_toggle;
    cfg_bad_beat  = v.bad_beat;
    cfg_xor       = v.data_xor;
    cfg_bad_rid   = v.bad_rid;
    aw_stall_left = v.aw_stall;
    cur_base      = v.base;
    cur_len       = v.len;
    w_beats = 0; wdata_bad = 0; wlast_bad = 0; aw_bad = 0; overlap_cnt = 0; aw_valid_seen = 0;
    exp_q.delete();
    for (int k = 0; k < v.exp_beats; k++) exp_q.push_back(v.seed + 32'(k));
    @(negedge clk);
    base = v.base; len = v.len; seed = v.seed; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    start_run(v);
    lat = 1;
    while (!done && lat < 500) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("v%0d_done_seen", idx), 64'(done), 64'd1);
    check($sformatf("v%0d_err_cnt", idx), 64'(err_cnt), 64'(v.exp_err));
    check($sformatf("v%0d_busy_at_done", idx), 64'(busy), 64'd0);
    if (v.exp_lat > 0) check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    @(posedge clk);
    #1;
    check($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
    check($sformatf("v%0d_err_hold", idx), 64'(err_cnt), 64'(v.exp_err));
    check($sformatf("v%0d_w_beats", idx), 64'(w_beats), 64'(v.exp_beats));
    check($sformatf("v%0d_wdata", idx), 64'(wdata_bad), 64'd0);
    check($sformatf("v%0d_wlast", idx), 64'(wlast_bad), 64'd0);
    check($sformatf("v%0d_ax_fields", idx), 64'(aw_bad), 64'd0);
    check($sformatf("v%0d_overlap", idx), 64'(overlap_cnt), 64'd0);
    check($sformatf("v%0d_aw_seen", idx), 64'(aw_valid_seen != 0), 64'(v.exp_beats != 0));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[8];
  vec_t mr;

  initial begin : test
    int g;
    n_checks = 0; n_errors = 0;
    cfg_no_b = 0; cfg_w_toggle = 0; cfg_bad_beat = -1; cfg_xor = '0; cfg_bad_rid = 0;
    aw_stall_left = 0; cur_base = '0; cur_len = '0;
    w_beats = 0; wdata_bad = 0; wlast_bad = 0; aw_bad = 0; overlap_cnt = 0; aw_valid_seen = 0;

    //            base     len   seed          stall tog bad xor    rid err   beats lat
    vecs[0] = '{16'h0100, 8'd3, 32'hA000_0000, 0,    0,  -1, 32'h0, 0,  9'd0, 4,    12};
    vecs[1] = '{16'h0200, 8'd3, 32'h1234_5678, 5,    1,  -1, 32'h0, 0,  9'd0, 4,    -1};
    vecs[2] = '{16'h0300, 8'd3, 32'h0000_0010, 0,    0,  2,  32'h1, 0,  9'd1, 4,    12};
    vecs[3] = '{16'h0300, 8'd3, 32'h0000_0010, 0,    0,  2,  32'h1, 1,  9'd1, 4,    12};
    vecs[4] = '{16'h0FF8, 8'd3, 32'hCAFE_0000, 0,    0,  -1, 32'h0, 0,  9'd1, 0,    1};
    vecs[5] = '{16'h0FF0, 8'd3, 32'h0BAD_0000, 0,    0,  -1, 32'h0, 0,  9'd0, 4,    12};
    vecs[6] = '{16'h0040, 8'd0, 32'hFFFF_FFFF, 0,    0,  -1, 32'h0, 0,  9'd0, 1,    6};
    vecs[7] = '{16'h0080, 8'd3, 32'hFFFF_FFFE, 0,    0,  -1, 32'h0, 0,  9'd0, 4,    12};
    mr      = '{16'h0500, 8'd7, 32'h0000_0055, 0,    0,  -1, 32'h0, 0,  9'd0, 8,    -1};

    rst = 1'b1; start = 1'b0; base = '0; len = '0; seed = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_valids", 64'({m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the middle of the W phase, then a clean run.
    start_run(mr);
    g = 0;
    while (w_beats < 2 && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("mr_reached_w", 64'(w_beats >= 2), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_wvalid", 64'(m_w_valid), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_err", 64'(err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0], 100);

`ifdef AXI_TGEN_TIMEOUT_EN
    begin : timeout_seq
      vec_t tv;
      int   n;
      tv = '{16'h0700, 8'd1, 32'h0000_1000, 0, 0, -1, 32'h0, 0, 9'd1, 2, -1};
      cfg_no_b = 1;
      start_run(tv);
      g = 0;
      while (w_beats < 2 && g < 50) begin
        @(posedge clk);
        #1;
        g++;
      end
      check("to_reached_b", 64'(w_beats), 64'd2);
      n = 0;
      while (!done && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("to_latency", 64'(n), 64'd16);
      check("to_flag", 64'(timeout), 64'd1);
      check("to_err", 64'(err_cnt), 64'd1);
      check("to_busy", 64'(busy), 64'd0);
      cfg_no_b = 0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
